io_controller: RTL and testbench
================================

IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, CPU data width; SWITCH_WIDTH, 16, switch bank width; DEBOUNCE_COUNT, 50000, consecutive stable samples needed to accept a button change (must be >=1); DEBOUNCE_WIDTH, 16, debounce counter width.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clock  in  1  system clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 is_input  in  1  CPU input request, level, held until confirmation seen.
REQ-006 is_output  in  1  CPU output request, level, held until confirmation seen.
REQ-007 cpu_data_out  in  DATA_WIDTH  value the CPU wants displayed.
REQ-008 button_n  in  1  raw asynchronous user button, active-low, may bounce.
REQ-009 switches  in  SWITCH_WIDTH  raw asynchronous user switches.
REQ-010 io_data_in  out  DATA_WIDTH  captured input word returned to CPU.
REQ-011 display_value  out  DATA_WIDTH  value driven to displays.
REQ-012 confirmation  out  1  handshake acknowledge to CPU control core.
REQ-013 waiting_user  out  1  high while waiting for user press.
REQ-014 protocol_error  out  1  sticky; set when is_input and is_output are both high in IDLE.

Function
REQ-015 button_n and switches SHALL each pass through a 2-flop synchronizer before use.
REQ-016 Debouncer: counter SHALL clear whenever synchronized button equals debounced state, else increment; on the cycle the counter reaches DEBOUNCE_COUNT-1 while still differing, debounced state SHALL toggle on the next edge and counter clear.
REQ-017 Press event = one-cycle debounced transition released->pressed; release event = pressed->released; a button already held when a request arrives SHALL NOT count as a press.
REQ-018 States: IDLE, WAIT_PRESS, WAIT_RELEASE, ACK.
REQ-019 IDLE: on is_input or is_output high, go to WAIT_PRESS next edge; button events ignored in IDLE.
REQ-020 Acceptance of is_output (without is_input) SHALL latch cpu_data_out into display_value on the same edge that enters WAIT_PRESS.
REQ-021 Both requests high in IDLE: treat as input, display_value unchanged, protocol_error set on that edge.
REQ-022 WAIT_PRESS: waiting_user=1; on press event capture zero-extended synchronized switches into io_data_in (input requests only) and go WAIT_RELEASE.
REQ-023 WAIT_PRESS or WAIT_RELEASE with both requests low (abort): go IDLE next edge, no capture, no confirmation.
REQ-024 WAIT_RELEASE: on release event go ACK; confirmation SHALL be registered and rise on the edge entering ACK.
REQ-025 ACK: confirmation held high until both requests low, then IDLE and confirmation low on the same edge (four-phase handshake).
REQ-026 io_data_in and display_value SHALL hold their values between captures.
REQ-027 Latency from raw button edge to debounced change: 2 + DEBOUNCE_COUNT cycles.

Reset
REQ-028 While reset=0 on a rising edge: state IDLE; synchronizers and debounced state = released (1); counter 0; io_data_in, display_value, confirmation, waiting_user, protocol_error = 0.
REQ-029 Reset asserted in any state SHALL abort the transaction; confirmation drops on that edge; no capture.

Verification (DEBOUNCE_COUNT=4)
REQ-030 Reset low 3 cycles with is_input=1, button_n=0 -> all outputs 0, state IDLE after release of reset.
REQ-031 switches=16'hA5C3, is_input=1, clean press 10 cycles then release -> io_data_in=32'h0000A5C3; confirmation rises 2+4+1 cycles after raw release, stays high until is_input=0, falls next edge.
REQ-032 is_input=1, button_n toggling every 2 cycles for 12 cycles then idle high -> no press event, waiting_user stays 1, confirmation 0.
REQ-033 cpu_data_out=32'hDEADBEEF, is_output=1 -> display_value=32'hDEADBEEF one edge later; confirmation only after press and release; io_data_in unchanged.
REQ-034 is_input=1, then dropped in WAIT_PRESS before press -> IDLE next edge, io_data_in unchanged, confirmation never asserted.
REQ-035 is_input=1 and is_output=1 together -> protocol_error=1 and stays 1 through later transactions until reset; transaction completes as input.

Source files
------------

// File: rtl/io_controller.sv
// io_controller
//   Bridges a CPU request/acknowledge handshake to a user button and a
//   switch bank. An input request waits for a debounced press/release of
//   the button and returns the switch value captured at the press. An
//   output request shows a CPU word on the displays and then waits for the
//   same press/release before acknowledging.
//
// Ports
//   clock          system clock, rising-edge active
//   reset          synchronous active-low reset
//   is_input       CPU input request (level, held until confirmation)
//   is_output      CPU output request (level, held until confirmation)
//   cpu_data_out   word to show on the displays for an output request
//   button_n       raw asynchronous push button, active-low, bouncing
//   switches       raw asynchronous switch bank
//   io_data_in     switch word captured for the CPU (zero-extended)
//   display_value  word driven to the displays
//   confirmation   registered four-phase acknowledge to the CPU
//   waiting_user   high while waiting for the user to press the button
//   protocol_error sticky flag: both requests seen together in IDLE
module io_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int SWITCH_WIDTH   = 16,
    parameter int DEBOUNCE_COUNT = 50000,
    parameter int DEBOUNCE_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic [DATA_WIDTH-1:0]   cpu_data_out,
    input  logic                    button_n,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic [DATA_WIDTH-1:0]   io_data_in,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    confirmation,
    output logic                    waiting_user,
    output logic                    protocol_error
);

    localparam logic [DEBOUNCE_WIDTH-1:0] LAST_COUNT = DEBOUNCE_WIDTH'(DEBOUNCE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_ACK          = 2'd3
    } state_t;

    state_t                    state_r;
    logic                      btn_meta_r;
    logic                      btn_sync_r;
    logic [SWITCH_WIDTH-1:0]   sw_meta_r;
    logic [SWITCH_WIDTH-1:0]   sw_sync_r;
    logic [DEBOUNCE_WIDTH-1:0] cnt_r;
    logic                      deb_r;
    logic                      deb_prev_r;
    logic                      mode_in_r;
    logic [DATA_WIDTH-1:0]     io_data_r;
    logic [DATA_WIDTH-1:0]     display_r;
    logic                      confirm_r;
    logic                      waiting_r;
    logic                      perr_r;

    logic                      press_s;
    logic                      release_s;
    logic                      no_req_s;

    // Button is active-low: released = 1, pressed = 0. Events are the
    // one-cycle window after the debounced level has flipped, so a button
    // already held when a request arrives never produces a press.
    assign press_s   = deb_prev_r & ~deb_r;
    assign release_s = ~deb_prev_r & deb_r;
    assign no_req_s  = ~is_input & ~is_output;

    assign io_data_in     = io_data_r;
    assign display_value  = display_r;
    assign confirmation   = confirm_r;
    assign waiting_user   = waiting_r;
    assign protocol_error = perr_r;

    // Input synchronizers and button debouncer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
            sw_meta_r  <= '0;
            sw_sync_r  <= '0;
            cnt_r      <= '0;
            deb_r      <= 1'b1;
            deb_prev_r <= 1'b1;
        end else begin
            btn_meta_r <= button_n;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
            deb_prev_r <= deb_r;
            if (btn_sync_r == deb_r) begin
                cnt_r <= '0;
            end else if (cnt_r == LAST_COUNT) begin
                // Enough consecutive differing samples: accept the new level.
                deb_r <= btn_sync_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + DEBOUNCE_WIDTH'(1);
            end
        end
    end

    // Handshake state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            mode_in_r <= 1'b0;
            io_data_r <= '0;
            display_r <= '0;
            confirm_r <= 1'b0;
            waiting_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_input || is_output) begin
                        state_r   <= ST_WAIT_PRESS;
                        waiting_r <= 1'b1;
                        // Simultaneous requests are served as an input.
                        mode_in_r <= is_input;
                        if (is_input && is_output) begin
                            perr_r <= 1'b1;
                        end
                        if (is_output && !is_input) begin
                            display_r <= cpu_data_out;
                        end
                    end
                end
                ST_WAIT_PRESS: begin
                    if (no_req_s) begin
                        state_r   <= ST_IDLE;
                        waiting_r <= 1'b0;
                    end else if (press_s) begin
                        state_r   <= ST_WAIT_RELEASE;
                        waiting_r <= 1'b0;
                        if (mode_in_r) begin
                            io_data_r <= DATA_WIDTH'(sw_sync_r);
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (no_req_s) begin
                        state_r <= ST_IDLE;
                    end else if (release_s) begin
                        state_r   <= ST_ACK;
                        confirm_r <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (no_req_s) begin
                        state_r   <= ST_IDLE;
                        confirm_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    confirm_r <= 1'b0;
                    waiting_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller (DEBOUNCE_COUNT = 4).
// Directed scenarios with fixed expected values, then randomized
// transactions; a cycle-level behavioural model is compared against the
// DUT outputs on every falling clock edge.
module tb_io_controller;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        is_input;
    logic        is_output;
    logic [31:0] cpu_data_out;
    logic        button_n;
    logic [15:0] switches;
    logic [31:0] io_data_in;
    logic [31:0] display_value;
    logic        confirmation;
    logic        waiting_user;
    logic        protocol_error;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit chk_en       = 1'b0;

    io_controller #(
        .DATA_WIDTH     (32),
        .SWITCH_WIDTH   (16),
        .DEBOUNCE_COUNT (DC),
        .DEBOUNCE_WIDTH (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .is_input       (is_input),
        .is_output      (is_output),
        .cpu_data_out   (cpu_data_out),
        .button_n       (button_n),
        .switches       (switches),
        .io_data_in     (io_data_in),
        .display_value  (display_value),
        .confirmation   (confirmation),
        .waiting_user   (waiting_user),
        .protocol_error (protocol_error)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases of a transaction: idle, waiting for press, waiting for release,
    // acknowledged. Button history is modelled as a two-sample delay line and
    // the debouncer as a run length of consecutive differing samples.
    localparam int PH_IDLE = 0, PH_PRESS = 1, PH_REL = 2, PH_ACK = 3;
    int          m_phase = PH_IDLE;
    int          m_run   = 0;
    logic        m_btn_hist[2] = '{1'b1, 1'b1};
    logic [15:0] m_sw_hist[2]  = '{16'h0, 16'h0};
    logic        m_deb = 1'b1, m_deb_prev = 1'b1, m_mode_in = 1'b0;
    logic [31:0] m_io = 32'h0, m_disp = 32'h0;
    logic        m_conf = 1'b0, m_wait = 1'b0, m_perr = 1'b0;

    always @(posedge clock) begin
        bit press_ev, rel_ev, no_req;
        if (!reset) begin
            m_phase = PH_IDLE; m_run = 0;
            m_btn_hist = '{1'b1, 1'b1}; m_sw_hist = '{16'h0, 16'h0};
            m_deb = 1'b1; m_deb_prev = 1'b1; m_mode_in = 1'b0;
            m_io = 32'h0; m_disp = 32'h0;
            m_conf = 1'b0; m_wait = 1'b0; m_perr = 1'b0;
        end else begin
            press_ev = (m_deb_prev == 1'b1) && (m_deb == 1'b0);
            rel_ev   = (m_deb_prev == 1'b0) && (m_deb == 1'b1);
            no_req   = !is_input && !is_output;
            if (m_phase == PH_IDLE) begin
                if (is_input || is_output) begin
                    m_phase = PH_PRESS; m_wait = 1'b1; m_mode_in = is_input;
                    if (is_input && is_output) m_perr = 1'b1;
                    if (is_output && !is_input) m_disp = cpu_data_out;
                end
            end else if (m_phase == PH_PRESS) begin
                if (no_req) begin
                    m_phase = PH_IDLE; m_wait = 1'b0;
                end else if (press_ev) begin
                    m_phase = PH_REL; m_wait = 1'b0;
                    if (m_mode_in) m_io = {16'h0, m_sw_hist[1]};
                end
            end else if (m_phase == PH_REL) begin
                if (no_req) m_phase = PH_IDLE;
                else if (rel_ev) begin m_phase = PH_ACK; m_conf = 1'b1; end
            end else begin
                if (no_req) begin m_phase = PH_IDLE; m_conf = 1'b0; end
            end
            m_deb_prev = m_deb;
            if (m_btn_hist[1] != m_deb) begin
                m_run++;
                if (m_run == DC) begin m_deb = m_btn_hist[1]; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_btn_hist[1] = m_btn_hist[0]; m_btn_hist[0] = button_n;
            m_sw_hist[1]  = m_sw_hist[0];  m_sw_hist[0]  = switches;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check_value("model_io_data_in", io_data_in, m_io);
            check_value("model_display", display_value, m_disp);
            check_value("model_confirmation", {31'h0, confirmation}, {31'h0, m_conf});
            check_value("model_waiting_user", {31'h0, waiting_user}, {31'h0, m_wait});
            check_value("model_protocol_error", {31'h0, protocol_error}, {31'h0, m_perr});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_conf(input int max_cycles, output int cycles);
        cycles = 0;
        while (confirmation !== 1'b1 && cycles < max_cycles) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic bounce(input logic settle);
        int nseg = $urandom_range(0, 3);
        for (int s = 0; s < nseg; s++) begin
            button_n = settle;  step($urandom_range(1, 2));
            button_n = ~settle; step($urandom_range(1, 2));
        end
        button_n = settle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int kind;
        int act;
        reset = 1'b0; is_input = 1'b1; is_output = 1'b0;
        cpu_data_out = 32'h0; button_n = 1'b0; switches = 16'h0;

        // Reset held three cycles with a request and a pressed button.
        step(1);
        chk_en = 1'b1;
        step(2);
        check_value("rst_io_data_in", io_data_in, 32'h0);
        check_value("rst_display", display_value, 32'h0);
        check_value("rst_confirmation", {31'h0, confirmation}, 32'h0);
        check_value("rst_waiting", {31'h0, waiting_user}, 32'h0);
        check_value("rst_perr", {31'h0, protocol_error}, 32'h0);
        reset = 1'b1; is_input = 1'b0; button_n = 1'b1;
        step(1);
        check_value("post_rst_idle", {31'h0, waiting_user}, 32'h0);
        step(3);

        // Clean input transaction.
        switches = 16'hA5C3; is_input = 1'b1;
        step(2);
        check_value("in_waiting", {31'h0, waiting_user}, 32'h1);
        button_n = 1'b0; step(10);
        check_value("in_pressed_no_conf", {31'h0, confirmation}, 32'h0);
        button_n = 1'b1;
        wait_conf(20, n);
        check_value("conf_latency", n, 32'd7);
        check_value("in_capture", io_data_in, 32'h0000A5C3);
        step(3);
        check_value("conf_held", {31'h0, confirmation}, 32'h1);
        is_input = 1'b0; step(1);
        check_value("conf_dropped", {31'h0, confirmation}, 32'h0);
        step(2);

        // Bouncing button never yields a press; then abort.
        is_input = 1'b1; step(2);
        for (int i = 0; i < 6; i++) begin
            button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        button_n = 1'b1; step(10);
        check_value("bounce_waiting", {31'h0, waiting_user}, 32'h1);
        check_value("bounce_no_conf", {31'h0, confirmation}, 32'h0);
        is_input = 1'b0; step(1);
        check_value("abort_idle", {31'h0, waiting_user}, 32'h0);
        step(2);
        check_value("abort_no_conf", {31'h0, confirmation}, 32'h0);
        check_value("abort_io_kept", io_data_in, 32'h0000A5C3);

        // Output transaction.
        cpu_data_out = 32'hDEADBEEF; is_output = 1'b1; step(1);
        check_value("out_display", display_value, 32'hDEADBEEF);
        button_n = 1'b0; step(8);
        check_value("out_no_conf_before_release", {31'h0, confirmation}, 32'h0);
        button_n = 1'b1;
        wait_conf(20, n);
        check_value("out_conf", {31'h0, confirmation}, 32'h1);
        check_value("out_io_kept", io_data_in, 32'h0000A5C3);
        is_output = 1'b0; step(2);

        // Both requests together: served as input, error latched.
        switches = 16'h1234; cpu_data_out = 32'h11111111;
        is_input = 1'b1; is_output = 1'b1; step(1);
        check_value("both_perr", {31'h0, protocol_error}, 32'h1);
        check_value("both_display_kept", display_value, 32'hDEADBEEF);
        button_n = 1'b0; step(8); button_n = 1'b1;
        wait_conf(20, n);
        check_value("both_conf", {31'h0, confirmation}, 32'h1);
        check_value("both_capture", io_data_in, 32'h00001234);
        is_input = 1'b0; is_output = 1'b0; step(2);
        cpu_data_out = 32'hCAFEF00D; is_output = 1'b1; step(1);
        check_value("later_display", display_value, 32'hCAFEF00D);
        button_n = 1'b0; step(8); button_n = 1'b1;
        wait_conf(20, n);
        check_value("perr_sticky", {31'h0, protocol_error}, 32'h1);
        is_output = 1'b0; step(2);

        // Randomized transactions checked against the model.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            is_input  = (kind != 1);
            is_output = (kind != 0);
            cpu_data_out = $urandom;
            switches = 16'($urandom);
            step(1 + $urandom_range(0, 2));
            act = $urandom_range(0, 9);
            if (act == 0) begin
                step($urandom_range(0, 6));
                is_input = 1'b0; is_output = 1'b0;
                step(2);
            end else if (act == 1) begin
                step($urandom_range(0, 10));
                reset = 1'b0; is_input = 1'b0; is_output = 1'b0;
                step(1);
                reset = 1'b1;
                step(2);
            end else begin
                bounce(1'b0);
                step(4); switches = 16'($urandom); step(4);
                bounce(1'b1);
                wait_conf(30, n);
                check_value("rand_conf", {31'h0, confirmation}, 32'h1);
                step($urandom_range(0, 2));
                is_input = 1'b0; is_output = 1'b0;
                step(2);
            end
        end

        // Reset clears the sticky error.
        reset = 1'b0; step(1);
        check_value("final_rst_perr", {31'h0, protocol_error}, 32'h0);
        check_value("final_rst_io", io_data_in, 32'h0);
        reset = 1'b1; step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
